// File: rtl/imem_boot_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_boot_loader_pkg
//
// Shared definitions for the boot-time instruction-memory loader:
//   - loader FSM state encoding (state_e)
//   - bank geometry (NUM_BANKS, BYTE_W)
//   - default frame start marker (DEF_SYNC_BYTE)
//   - SRAM control levels for idle and write cycles
//
// The CHECK state is always present in the encoding so the debug state port
// keeps the same meaning in every build.  It is only ever reached when
// IMEM_BOOT_LOADER_CHECKSUM_EN is defined.
// -----------------------------------------------------------------------------
package imem_boot_loader_pkg;

  localparam int NUM_BANKS = 4;
  localparam int BYTE_W    = 8;

  localparam logic [BYTE_W-1:0] DEF_SYNC_BYTE = 8'hA5;

  // SRAM controls are active-low: idle deselects the bank and masks all bits.
  localparam logic              IDLE_CEN   = 1'b1;
  localparam logic              IDLE_GWEN  = 1'b1;
  localparam logic [BYTE_W-1:0] IDLE_WEN   = 8'hFF;
  localparam logic              WRITE_CEN  = 1'b0;
  localparam logic              WRITE_GWEN = 1'b0;
  localparam logic [BYTE_W-1:0] WRITE_WEN  = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SYNC   = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_LEN_HI = 3'd3,
    ST_DATA   = 3'd4,
    ST_CHECK  = 3'd5,
    ST_DONE   = 3'd6,
    ST_ERROR  = 3'd7
  } state_e;

  // A load is in progress from SYNC through CHECK.
  function automatic logic state_is_busy(input state_e s);
    return (s == ST_SYNC) || (s == ST_LEN_LO) || (s == ST_LEN_HI) ||
           (s == ST_DATA) || (s == ST_CHECK);
  endfunction

endpackage

// File: rtl/imem_boot_loader_port_mux.sv
// -----------------------------------------------------------------------------
// imem_port_mux
//
// Purely combinational per-bank selector between the loader's SRAM drive and
// the core's own imem port.  With sel_core=1 every core signal reaches the
// SRAM unchanged; with sel_core=0 the loader owns all banks.
//
// Ports (all arrays are [0:NUM_BANKS-1]):
//   sel_core                        1 = pass core signals, 0 = loader drive
//   cen_ld/gwen_ld/wen_ld/a_ld/d_ld loader-side controls, address, data
//   cen_core/.../d_core             core-side controls, address, data
//   cen_imem/.../d_imem             to the SRAM banks
// -----------------------------------------------------------------------------
module imem_port_mux
  import imem_boot_loader_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic              sel_core,
  input  logic              cen_ld    [0:NUM_BANKS-1],
  input  logic              gwen_ld   [0:NUM_BANKS-1],
  input  logic [BYTE_W-1:0] wen_ld    [0:NUM_BANKS-1],
  input  logic [ADDR_W-1:0] a_ld      [0:NUM_BANKS-1],
  input  logic [BYTE_W-1:0] d_ld      [0:NUM_BANKS-1],
  input  logic              cen_core  [0:NUM_BANKS-1],
  input  logic              gwen_core [0:NUM_BANKS-1],
  input  logic [BYTE_W-1:0] wen_core  [0:NUM_BANKS-1],
  input  logic [ADDR_W-1:0] a_core    [0:NUM_BANKS-1],
  input  logic [BYTE_W-1:0] d_core    [0:NUM_BANKS-1],
  output logic              cen_imem  [0:NUM_BANKS-1],
  output logic              gwen_imem [0:NUM_BANKS-1],
  output logic [BYTE_W-1:0] wen_imem  [0:NUM_BANKS-1],
  output logic [ADDR_W-1:0] a_imem    [0:NUM_BANKS-1],
  output logic [BYTE_W-1:0] d_imem    [0:NUM_BANKS-1]
);

  always_comb begin
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (sel_core) begin
        cen_imem[i]  = cen_core[i];
        gwen_imem[i] = gwen_core[i];
        wen_imem[i]  = wen_core[i];
        a_imem[i]    = a_core[i];
        d_imem[i]    = d_core[i];
      end else begin
        cen_imem[i]  = cen_ld[i];
        gwen_imem[i] = gwen_ld[i];
        wen_imem[i]  = wen_ld[i];
        a_imem[i]    = a_ld[i];
        d_imem[i]    = d_ld[i];
      end
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// -----------------------------------------------------------------------------
// imem_boot_loader
//
// Boot-time loader in front of the four byte-wide instruction SRAM banks.
// A framed image arrives as a byte stream:
//   SYNC_BYTE, LEN_LO, LEN_HI, 4*LEN data bytes [, checksum byte]
// Data bytes fill a word buffer in lane order 0..3; byte lane i goes to
// bank i.  Each completed word is written to all four banks in one cycle at
// the word's index.  The core is held in reset until the image is loaded;
// after that the core's imem port is passed straight through to the banks.
//
// Configuration macro: IMEM_BOOT_LOADER_CHECKSUM_EN
//   defined   - one checksum byte follows the data; it must equal the XOR of
//               both length bytes and all data bytes, else the frame is
//               rejected (ERROR, core kept in reset).
//   undefined - no checksum; anything after the data is ignored.
//
// Handshake: rx_valid is a one-cycle strobe qualifying rx_data; a byte is
//   consumed on every clock edge where rx_valid=1 and the FSM is in a
//   receiving state.  There is no backpressure, so every state that can see
//   a byte must take it in that cycle.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   rx_data, rx_valid   byte stream from the UART receiver
//   start               arms a load (ignored while busy)
//   busy, done, error   status levels
//   core_rst            active-high reset to the core (low only in DONE)
//   *_core [0:3]        core-side imem port
//   *_imem [0:3]        to the SRAM banks
//   state_dbg           current FSM state
// -----------------------------------------------------------------------------
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int                ADDR_W    = 9,
  parameter int                MAX_WORDS = 512,
  parameter logic [BYTE_W-1:0] SYNC_BYTE = DEF_SYNC_BYTE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              core_rst,
  input  logic              CEN_core  [0:NUM_BANKS-1],
  input  logic              GWEN_core [0:NUM_BANKS-1],
  input  logic [BYTE_W-1:0] WEN_core  [0:NUM_BANKS-1],
  input  logic [ADDR_W-1:0] A_core    [0:NUM_BANKS-1],
  input  logic [BYTE_W-1:0] D_core    [0:NUM_BANKS-1],
  output logic              CEN_imem  [0:NUM_BANKS-1],
  output logic              GWEN_imem [0:NUM_BANKS-1],
  output logic [BYTE_W-1:0] WEN_imem  [0:NUM_BANKS-1],
  output logic [ADDR_W-1:0] A_imem    [0:NUM_BANKS-1],
  output logic [BYTE_W-1:0] D_imem    [0:NUM_BANKS-1],
  output state_e            state_dbg
);

  localparam logic [15:0]     MAX_LEN = 16'(MAX_WORDS);
  localparam logic [ADDR_W:0] IDX_ONE = (ADDR_W+1)'(1);

  state_e state_q, state_d;

  logic [1:0]        lane_q;
  logic [BYTE_W-1:0] buf_q      [0:NUM_BANKS-2];
  logic [ADDR_W:0]   word_idx_q;
  logic [BYTE_W-1:0] len_lo_q;
  logic [15:0]       len_q;

  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [BYTE_W-1:0] wr_data_q  [0:NUM_BANKS-1];

`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] chk_acc_q;
`endif

  logic [15:0] len_full;
  logic        last_word;
  logic        last_wr;
  logic        data_byte;
  logic        rearm;

  // Length as it becomes complete on the LEN_HI byte.
  assign len_full = {rx_data, len_lo_q};

  // The word currently being written is the last one of the image.
  assign last_word = ((16'(word_idx_q) + 16'd1) == len_q);
  assign last_wr   = wr_en_q && last_word;

  assign rearm = start &&
                 ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERROR));

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    data_byte = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_SYNC;
      end
      ST_SYNC: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) state_d = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (rx_valid) state_d = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        if (rx_valid) begin
          if (len_full == 16'd0)          state_d = ST_DONE;
          else if (len_full > MAX_LEN)    state_d = ST_ERROR;
          else                            state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        // During the final write cycle every data byte has been taken, so a
        // byte arriving now belongs to whatever follows the image.
        data_byte = rx_valid && !last_wr;
        if (last_wr) begin
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
          // Back-to-back streams deliver the checksum during the last write
          // cycle; judge it here rather than lose it.
          if (rx_valid) state_d = (rx_data == chk_acc_q) ? ST_DONE : ST_ERROR;
          else          state_d = ST_CHECK;
`else
          state_d = ST_DONE;
`endif
        end
      end
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (rx_valid) state_d = (rx_data == chk_acc_q) ? ST_DONE : ST_ERROR;
      end
`endif
      ST_DONE, ST_ERROR: begin
        if (start) state_d = ST_SYNC;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Datapath: length capture, word assembly, write registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_q     <= 2'd0;
      word_idx_q <= '0;
      len_lo_q   <= '0;
      len_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      for (int i = 0; i < NUM_BANKS-1; i++) buf_q[i] <= '0;
      for (int i = 0; i < NUM_BANKS; i++)   wr_data_q[i] <= '0;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
      chk_acc_q  <= '0;
`endif
    end else begin
      // The write strobe lasts exactly one cycle.
      wr_en_q <= 1'b0;
      if (wr_en_q) word_idx_q <= word_idx_q + IDX_ONE;

      if (rearm) begin
        lane_q     <= 2'd0;
        word_idx_q <= '0;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
        chk_acc_q  <= '0;
`endif
      end

      if ((state_q == ST_LEN_LO) && rx_valid) begin
        len_lo_q <= rx_data;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
        chk_acc_q <= chk_acc_q ^ rx_data;
`endif
      end

      if ((state_q == ST_LEN_HI) && rx_valid) begin
        len_q <= len_full;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
        chk_acc_q <= chk_acc_q ^ rx_data;
`endif
      end

      if (data_byte) begin
        lane_q <= lane_q + 2'd1;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
        chk_acc_q <= chk_acc_q ^ rx_data;
`endif
        if (lane_q == 2'd3) begin
          // Lane 3 goes straight to the write register, freeing the buffer
          // for the next word while this one is being written.
          wr_data_q[0] <= buf_q[0];
          wr_data_q[1] <= buf_q[1];
          wr_data_q[2] <= buf_q[2];
          wr_data_q[3] <= rx_data;
          wr_addr_q    <= word_idx_q[ADDR_W-1:0];
          wr_en_q      <= 1'b1;
        end else begin
          buf_q[lane_q] <= rx_data;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Status outputs
  // ---------------------------------------------------------------------------
  assign busy      = state_is_busy(state_q);
  assign done      = (state_q == ST_DONE);
  assign error     = (state_q == ST_ERROR);
  assign core_rst  = (state_q != ST_DONE);
  assign state_dbg = state_q;

  // ---------------------------------------------------------------------------
  // Loader-side SRAM drive: all banks written together, byte lane i to bank i
  // ---------------------------------------------------------------------------
  logic              cen_ld  [0:NUM_BANKS-1];
  logic              gwen_ld [0:NUM_BANKS-1];
  logic [BYTE_W-1:0] wen_ld  [0:NUM_BANKS-1];
  logic [ADDR_W-1:0] a_ld    [0:NUM_BANKS-1];
  logic [BYTE_W-1:0] d_ld    [0:NUM_BANKS-1];

  always_comb begin
    for (int i = 0; i < NUM_BANKS; i++) begin
      cen_ld[i]  = wr_en_q ? WRITE_CEN  : IDLE_CEN;
      gwen_ld[i] = wr_en_q ? WRITE_GWEN : IDLE_GWEN;
      wen_ld[i]  = wr_en_q ? WRITE_WEN  : IDLE_WEN;
      a_ld[i]    = wr_addr_q;
      d_ld[i]    = wr_data_q[i];
    end
  end

  imem_port_mux #(
    .ADDR_W (ADDR_W)
  ) u_port_mux (
    .sel_core  (done),
    .cen_ld    (cen_ld),
    .gwen_ld   (gwen_ld),
    .wen_ld    (wen_ld),
    .a_ld      (a_ld),
    .d_ld      (d_ld),
    .cen_core  (CEN_core),
    .gwen_core (GWEN_core),
    .wen_core  (WEN_core),
    .a_core    (A_core),
    .d_core    (D_core),
    .cen_imem  (CEN_imem),
    .gwen_imem (GWEN_imem),
    .wen_imem  (WEN_imem),
    .a_imem    (A_imem),
    .d_imem    (D_imem)
  );

endmodule

// File: tb/tb_imem_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_boot_loader
//
// Directed bench for imem_boot_loader.  Frames are driven byte by byte; each
// expected SRAM write {address, word} is queued as its bytes are sent and
// popped by a monitor when a write cycle appears on the banks.  A small SRAM
// model captures the writes so loaded images can be read back.
// Honours IMEM_BOOT_LOADER_CHECKSUM_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_imem_boot_loader;
  import imem_boot_loader_pkg::*;

  localparam int ADDR_W = 9;
  localparam int NB     = NUM_BANKS;
  localparam int EW     = ADDR_W + 32;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic              clk;
  logic              rst;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              start;
  logic              busy, done, error, core_rst;
  logic              CEN_core  [0:NB-1];
  logic              GWEN_core [0:NB-1];
  logic [7:0]        WEN_core  [0:NB-1];
  logic [ADDR_W-1:0] A_core    [0:NB-1];
  logic [7:0]        D_core    [0:NB-1];
  logic              CEN_imem  [0:NB-1];
  logic              GWEN_imem [0:NB-1];
  logic [7:0]        WEN_imem  [0:NB-1];
  logic [ADDR_W-1:0] A_imem    [0:NB-1];
  logic [7:0]        D_imem    [0:NB-1];
  state_e            state_dbg;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  imem_boot_loader #(
    .ADDR_W    (ADDR_W),
    .MAX_WORDS (512),
    .SYNC_BYTE (8'hA5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .core_rst  (core_rst),
    .CEN_core  (CEN_core),
    .GWEN_core (GWEN_core),
    .WEN_core  (WEN_core),
    .A_core    (A_core),
    .D_core    (D_core),
    .CEN_imem  (CEN_imem),
    .GWEN_imem (GWEN_imem),
    .WEN_imem  (WEN_imem),
    .A_imem    (A_imem),
    .D_imem    (D_imem),
    .state_dbg (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [EW-1:0]     exp_q[$];
  int                checks   = 0;
  int                errors   = 0;
  int                wr_count = 0;
  logic [7:0]        bank_mem [0:NB-1][0:511];
  logic [31:0]       img      [0:511];
  logic [7:0]        tb_chk;
  logic [ADDR_W-1:0] exp_addr;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] ctrl_bits();
    return {CEN_imem[3], CEN_imem[2], CEN_imem[1], CEN_imem[0],
            GWEN_imem[3], GWEN_imem[2], GWEN_imem[1], GWEN_imem[0],
            WEN_imem[3], WEN_imem[2], WEN_imem[1], WEN_imem[0]};
  endfunction

  function automatic logic [67:0] ad_bits();
    return {A_imem[3], A_imem[2], A_imem[1], A_imem[0],
            D_imem[3], D_imem[2], D_imem[1], D_imem[0]};
  endfunction

  function automatic logic [31:0] mem_word(input int a);
    return {bank_mem[3][a], bank_mem[2][a], bank_mem[1][a], bank_mem[0][a]};
  endfunction

  // Write-cycle monitor (loader side only).
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst === 1'b1 && done === 1'b0 && CEN_imem[0] === 1'b0) begin
      wr_count++;
      check("write_expected", 128'(exp_q.size() != 0), 128'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("write_addr_data", 128'(ad_bits()),
              128'({e[EW-1:32], e[EW-1:32], e[EW-1:32], e[EW-1:32], e[31:0]}));
        check("write_ctrl", 128'(ctrl_bits()), 128'd0);
      end
    end
  end

  // Behavioural SRAM banks.
  always @(posedge clk) begin
    for (int i = 0; i < NB; i++)
      if (CEN_imem[i] === 1'b0 && GWEN_imem[i] === 1'b0)
        bank_mem[i][A_imem[i]] <= D_imem[i];
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (all leave the caller 1 time unit after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    tick(gap);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic begin_frame(input logic [7:0] lo, input logic [7:0] hi, input int gap);
    tb_chk   = lo ^ hi;
    exp_addr = '0;
    send_byte(8'hA5, gap);
    send_byte(lo, gap);
    send_byte(hi, gap);
  endtask

  task automatic load_word(input logic [31:0] w, input int gap);
    exp_q.push_back({exp_addr, w});
    exp_addr = exp_addr + 1'b1;
    for (int i = 0; i < 4; i++) begin
      tb_chk = tb_chk ^ w[8*i +: 8];
      send_byte(w[8*i +: 8], gap);
    end
  endtask

  task automatic core_idle();
    for (int i = 0; i < NB; i++) begin
      CEN_core[i] = 1'b1; GWEN_core[i] = 1'b1; WEN_core[i] = 8'hFF;
      A_core[i] = '0; D_core[i] = '0;
    end
  endtask

  // Watchdog; the sequence below uses fixed delays only.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int wr_base;
    int mism;
    logic [31:0] w;

    rst = 1'b0; rx_valid = 1'b0; rx_data = '0; start = 1'b0;
    tb_chk = '0; exp_addr = '0;
    // Core drives an active write during reset; the banks must not see it.
    for (int i = 0; i < NB; i++) begin
      CEN_core[i] = 1'b0; GWEN_core[i] = 1'b0; WEN_core[i] = 8'h00;
      A_core[i] = 9'h1FF; D_core[i] = 8'h55;
    end
    tick(3);

    // --- Reset values ---
    check("rst_status", {busy, done, error, core_rst}, 4'b0001);
    check("rst_state", state_dbg, ST_IDLE);
    check("rst_ctrl", 128'(ctrl_bits()), {88'd0, 4'hF, 4'hF, 32'hFFFF_FFFF});
    check("rst_ad", 128'(ad_bits()), 128'd0);
    core_idle();
    rst = 1'b1;
    tick(2);

    // rx traffic in IDLE is ignored.
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 1);
    check("idle_ignores_rx", {state_dbg, busy}, {ST_IDLE, 1'b0});

    // --- Normal load with gaps of 3 cycles ---
    pulse_start();
    check("arm_busy", {busy, done, core_rst}, 3'b101);
    begin_frame(8'h02, 8'h00, 3);
    load_word(32'h0000_0513, 3);
    load_word(32'h0010_0593, 3);
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    send_byte(tb_chk, 0);
`else
    send_byte(8'h77, 0);
`endif
    tick(2);
    check("load2_status", {busy, done, error, core_rst}, 4'b0100);
    check("load2_queue_empty", 128'(exp_q.size()), 128'd0);
    check("load2_write_count", 128'(wr_count), 128'd2);
    check("load2_readback", {mem_word(1), mem_word(0)}, {32'h0010_0593, 32'h0000_0513});

    // --- Pass-through after done ---
    for (int i = 0; i < NB; i++) CEN_core[i] = 1'b0;
    #1;
    check("pass_cen_low", 128'(ctrl_bits()), {88'd0, 4'h0, 4'hF, 32'hFFFF_FFFF});
    for (int i = 0; i < NB; i++) begin
      CEN_core[i] = 1'b1;
      A_core[i]   = ADDR_W'(9'h100 + i * 9'h15);
      D_core[i]   = 8'hC0 + 8'(i);
    end
    #1;
    check("pass_cen_high", 128'(ctrl_bits()), {88'd0, 4'hF, 4'hF, 32'hFFFF_FFFF});
    check("pass_ad", 128'(ad_bits()),
          128'({9'h13F, 9'h12A, 9'h115, 9'h100, 8'hC3, 8'hC2, 8'hC1, 8'hC0}));
    core_idle();
    tick(1);

    // --- Re-arm from DONE, then length 0 ---
    pulse_start();
    check("rearm_done", {state_dbg, busy, done, core_rst}, {ST_SYNC, 3'b101});
    wr_base = wr_count;
    begin_frame(8'h00, 8'h00, 0);
    check("len0_done", {done, error, core_rst}, 3'b100);
    tick(3);
    check("len0_no_write", 128'(wr_count - wr_base), 128'd0);

    // --- Over-length (0x0201 words) ---
    pulse_start();
    begin_frame(8'h01, 8'h02, 0);
    check("overlen_error", {busy, done, error, core_rst}, 4'b0011);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    tick(3);
    check("overlen_no_write", 128'(wr_count - wr_base), 128'd0);
    check("overlen_stays_error", state_dbg, ST_ERROR);

    // start is ignored while busy, re-arms from ERROR.
    pulse_start();
    check("rearm_error", {state_dbg, busy, error, core_rst}, {ST_SYNC, 3'b101});
    pulse_start();
    check("start_ignored_busy", state_dbg, ST_SYNC);

    // --- 512-word image, rx_valid every cycle ---
    send_byte(8'h11, 0);   // discarded in SYNC
    send_byte(8'hA4, 0);   // discarded in SYNC
    wr_base = wr_count;
    begin_frame(8'h00, 8'h02, 0);
    check("big_in_data", state_dbg, ST_DATA);
    for (int a = 0; a < 512; a++) begin
      img[a] = $urandom;
      load_word(img[a], 0);
    end
    check("big_last_write_cycle", {done, CEN_imem[0]}, 2'b00);
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    send_byte(tb_chk, 0);
`else
    send_byte(8'h5A, 0);
`endif
    check("big_done_next_cycle", {done, error, core_rst}, 3'b100);
    tick(2);
    check("big_queue_empty", 128'(exp_q.size()), 128'd0);
    check("big_write_count", 128'(wr_count - wr_base), 128'd512);
    mism = 0;
    for (int a = 0; a < 512; a++)
      if (mem_word(a) !== img[a]) mism++;
    check("big_readback_mismatches", 128'(mism), 128'd0);

    // --- Reset during the 3rd byte of word 5 ---
    pulse_start();
    wr_base = wr_count;
    begin_frame(8'h08, 8'h00, 0);
    for (int k = 0; k < 5; k++) load_word($urandom, 0);
    w = $urandom;
    send_byte(w[7:0], 0);
    send_byte(w[15:8], 0);
    rx_data  = w[23:16];
    rx_valid = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("midrst_status", {busy, done, error, core_rst}, 4'b0001);
    check("midrst_state", state_dbg, ST_IDLE);
    check("midrst_ctrl", 128'(ctrl_bits()), {88'd0, 4'hF, 4'hF, 32'hFFFF_FFFF});
    check("midrst_ad", 128'(ad_bits()), 128'd0);
    rx_valid = 1'b0;
    tick(1);
    rst = 1'b1;
    send_byte(w[31:24], 0);
    tick(4);
    check("midrst_writes", 128'(wr_count - wr_base), 128'd5);
    check("midrst_queue_empty", 128'(exp_q.size()), 128'd0);
    check("midrst_idle", {state_dbg, busy}, {ST_IDLE, 1'b0});

    // --- Trailing byte / checksum handling ---
    pulse_start();
    begin_frame(8'h01, 8'h00, 1);
    load_word(32'h4433_2211, 1);
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    check("chk_wait_state", state_dbg, ST_CHECK);
    send_byte(tb_chk ^ 8'hFF, 1);
    check("chk_bad_error", {busy, done, error, core_rst}, 4'b0011);
    pulse_start();
    begin_frame(8'h01, 8'h00, 1);
    load_word(32'h8877_6655, 1);
    send_byte(tb_chk, 1);
    check("chk_good_done", {busy, done, error, core_rst}, 4'b0100);
`else
    check("trail_done_before_byte", {done, error}, 2'b10);
    send_byte(8'hEE, 1);
    check("trail_ignored_done", {busy, done, error, core_rst}, 4'b0100);
`endif
    tick(2);
    check("final_queue_empty", 128'(exp_q.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
